// File: rtl/cpu_ctrl_if.sv
// Memory request/acknowledge bus between the control unit and instruction/data memory.
// Latency: purely wires; a command stays on the bus until the memory acknowledges it.
// Backpressure: the memory stalls the controller by holding mem_ack low.
interface cpu_ctrl_if #(
  parameter int PC_W = 9
);
  logic [1:0]      mem_cmd;    // 00 none, 01 read, 10 write
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [15:0]     mem_rdata;

  modport master (output mem_cmd, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_cmd, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/cpu_ctrl.sv
// Multicycle control unit: fetch, decode, ALU/MOV/LDR/STR sequencing, HALT and illegal trap.
// Latency: MOVimm 3, MOVreg/MVN/CMP 5, ADD/AND/LDR 6, STR 8 cycles with single-cycle ack.
// Backpressure: waits in IF1/MEMRD/MEMWR until mem_ack; CPU_CTRL_MEM_TIMEOUT_EN bounds the wait.
module cpu_ctrl #(
  parameter int PC_W        = 9,
  parameter int DATA_W      = 16,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  cpu_ctrl_if.master        mem,
  input  logic [DATA_W-1:0] dp_out,
  output logic [15:0]       ir,
  output logic [PC_W-1:0]   pc,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic [3:0]        vsel,
  output logic [2:0]        nsel,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err
);

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_DECODE, S_WIMM, S_GETA, S_GETB, S_CALC, S_WRC,
    S_CMP, S_ACALC, S_LDADDR, S_MEMRD, S_GETD, S_PASS, S_MEMWR, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc_q, addr_q;
  logic            illegal_q, bus_err_q;
  logic            dec_illegal;
  logic            mem_to;

  // Instruction classes, decoded from the held instruction
  logic [2:0] opc;
  logic [1:0] op;
  logic       is_alu, is_movreg, is_mvn, is_cmp, is_ldr;
  assign opc       = ir_q[15:13];
  assign op        = ir_q[12:11];
  assign is_alu    = (opc == 3'b101);
  assign is_movreg = (opc == 3'b110) && (op == 2'b00);
  assign is_mvn    = is_alu && (op == 2'b11);
  assign is_cmp    = is_alu && (op == 2'b01);
  assign is_ldr    = (opc == 3'b011);

  // Only the low PC_W bits of the datapath output form an address
  logic unused_dp;
  assign unused_dp = ^dp_out[DATA_W-1:PC_W];

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  assign waiting = (state_q == S_IF1) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // An ack on the final allowed cycle wins over the timeout
  assign mem_to  = waiting && !mem.mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Count consecutive wait cycles; restart on every state entry
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Wait-cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign mem_to = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    if (mem.mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (opc)
          3'b110: begin
            if (op == 2'b10)      state_d = S_WIMM;
            else if (op == 2'b00) state_d = S_GETB;
            else begin state_d = S_HALT; dec_illegal = 1'b1; end
          end
          3'b101:  state_d = (op == 2'b11) ? S_GETB : S_GETA;
          3'b011, 3'b100: begin
            if (op == 2'b00) state_d = S_GETA;
            else begin state_d = S_HALT; dec_illegal = 1'b1; end
          end
          3'b111:  state_d = S_HALT;
          default: begin state_d = S_HALT; dec_illegal = 1'b1; end
        endcase
      end
      S_WIMM:   state_d = S_IF1;
      S_GETA:   state_d = is_alu ? S_GETB : S_ACALC;
      S_GETB:   state_d = is_cmp ? S_CMP : S_CALC;
      S_CALC:   state_d = S_WRC;
      S_WRC:    state_d = S_IF1;
      S_CMP:    state_d = S_IF1;
      S_ACALC:  state_d = S_LDADDR;
      S_LDADDR: state_d = is_ldr ? S_MEMRD : S_GETD;
      S_MEMRD:  if (mem.mem_ack) state_d = S_IF1;
      S_GETD:   state_d = S_PASS;
      S_PASS:   state_d = S_MEMWR;
      S_MEMWR:  if (mem.mem_ack) state_d = S_IF1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
    if (mem_to) state_d = S_HALT;
  end

  // Instruction, program counter, address and sticky status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q      <= '0;
      pc_q      <= PC_W'(RESET_PC);
      addr_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == S_IF1 && mem.mem_ack) begin
        ir_q <= mem.mem_rdata;
        pc_q <= pc_q + PC_W'(1);
      end
      if (state_q == S_LDADDR) addr_q <= dp_out[PC_W-1:0];
      if (state_q == S_DECODE && dec_illegal) illegal_q <= 1'b1;
      if (mem_to) bus_err_q <= 1'b1;
    end
  end

  // Moore strobes per state; MEMRD writeback additionally depends on ack
  always_comb begin
    loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
    asel  = 1'b0; bsel  = 1'b0; write = 1'b0;
    vsel  = 4'b0000; nsel = 3'b000; alu_op = 2'b00; shift = 2'b00;
    mem.mem_cmd  = 2'b00;
    mem.mem_addr = '0;
    case (state_q)
      S_IF1:    begin mem.mem_cmd = 2'b01; mem.mem_addr = pc_q; end
      S_WIMM:   begin nsel = 3'b001; vsel = 4'b0010; write = 1'b1; end
      S_GETA:   begin nsel = 3'b001; loada = 1'b1; end
      S_GETB:   begin nsel = 3'b100; loadb = 1'b1; end
      S_CALC:   begin loadc = 1'b1; asel = is_movreg || is_mvn; end
      S_WRC:    begin nsel = 3'b010; vsel = 4'b1000; write = 1'b1; end
      S_CMP:    loads = 1'b1;
      S_ACALC:  begin bsel = 1'b1; loadc = 1'b1; end
      S_MEMRD:  begin
        mem.mem_cmd  = 2'b01;
        mem.mem_addr = addr_q;
        if (mem.mem_ack) begin nsel = 3'b010; vsel = 4'b0001; write = 1'b1; end
      end
      S_GETD:   begin nsel = 3'b010; loadb = 1'b1; end
      S_PASS:   begin asel = 1'b1; loadc = 1'b1; end
      S_MEMWR:  begin mem.mem_cmd = 2'b10; mem.mem_addr = addr_q; end
      default:  ;
    endcase
    // ALU op and shifter follow the instruction only while it is executing
    if (state_q == S_GETA || state_q == S_GETB || state_q == S_CALC ||
        state_q == S_WRC  || state_q == S_CMP) begin
      if (is_alu) alu_op = op;
      if (is_alu || is_movreg) shift = ir_q[4:3];
    end
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: drives the memory bus and dp_out, checks strobes cycle by cycle.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_ack is held low for chosen cycles to stretch memory waits.
module tb_cpu_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] dp_out = '0;
  logic [15:0] ir;
  logic [8:0]  pc;
  logic        loada, loadb, loadc, loads, asel, bsel, write;
  logic [3:0]  vsel;
  logic [2:0]  nsel;
  logic [1:0]  alu_op, shift;
  logic        halted, illegal, bus_err;
  logic [6:0]  strb;
  int          total = 0;
  int          bad = 0;

  cpu_ctrl_if #(.PC_W(9)) bus ();

  cpu_ctrl #(.PC_W(9), .DATA_W(16), .RESET_PC(0), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .mem(bus), .dp_out(dp_out), .ir(ir), .pc(pc),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .bsel(bsel), .write(write), .vsel(vsel), .nsel(nsel), .alu_op(alu_op),
    .shift(shift), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // strobe vector order: loada loadb loadc loads asel bsel write
  assign strb = {loada, loadb, loadc, loads, asel, bsel, write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0000;
    #12;
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
    total++; if (ir !== 16'h0000) begin bad++; $display("FAIL rst_ir got=%h want=0", ir); end
    total++; if (bus.mem_cmd !== 2'b00) begin bad++; $display("FAIL rst_cmd got=%b want=00", bus.mem_cmd); end
    total++; if (strb !== 7'b0) begin bad++; $display("FAIL rst_strb got=%b want=0", strb); end
    total++; if ({halted, illegal, bus_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {halted, illegal, bus_err}); end
    @(negedge clk); reset = 1'b1;
    tick();
    total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'd0) begin bad++; $display("FAIL rst_if1 cmd=%b addr=%h want 01/0", bus.mem_cmd, bus.mem_addr); end
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL rst_ack_ignored pc=%h want=0", pc); end
  endtask

  task automatic test_movimm();
    bus.mem_rdata = 16'hD007;
    tick();
    total++; if (ir !== 16'hD007 || pc !== 9'd1) begin bad++; $display("FAIL mov_fetch ir=%h pc=%h want D007/1", ir, pc); end
    total++; if (bus.mem_cmd !== 2'b00) begin bad++; $display("FAIL mov_dec_cmd got=%b want=00", bus.mem_cmd); end
    tick();
    total++; if (strb !== 7'b0000001 || nsel !== 3'b001 || vsel !== 4'b0010) begin bad++; $display("FAIL mov_wimm strb=%b nsel=%b vsel=%b want 0000001/001/0010", strb, nsel, vsel); end
    tick();
    total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'd1 || strb !== 7'b0) begin bad++; $display("FAIL mov_if1 cmd=%b addr=%h strb=%b want 01/1/0", bus.mem_cmd, bus.mem_addr, strb); end
  endtask

  task automatic test_add();
    bus.mem_rdata = 16'hA0A0;
    tick();
    tick();
    total++; if (strb !== 7'b1000000 || nsel !== 3'b001) begin bad++; $display("FAIL add_geta strb=%b nsel=%b want 1000000/001", strb, nsel); end
    tick();
    total++; if (strb !== 7'b0100000 || nsel !== 3'b100) begin bad++; $display("FAIL add_getb strb=%b nsel=%b want 0100000/100", strb, nsel); end
    tick();
    total++; if (strb !== 7'b0010000) begin bad++; $display("FAIL add_calc strb=%b want 0010000", strb); end
    tick();
    total++; if (strb !== 7'b0000001 || nsel !== 3'b010 || vsel !== 4'b1000 || alu_op !== 2'b00) begin bad++; $display("FAIL add_wrc strb=%b nsel=%b vsel=%b aluop=%b", strb, nsel, vsel, alu_op); end
    tick();
    total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'd2) begin bad++; $display("FAIL add_if1 cmd=%b addr=%h want 01/2", bus.mem_cmd, bus.mem_addr); end
  endtask

  task automatic test_alu_variants();
    // AND R?: 101/10
    bus.mem_rdata = 16'hB000;
    tick(); tick(); tick(); tick();
    total++; if (strb !== 7'b0010000 || alu_op !== 2'b10) begin bad++; $display("FAIL and_calc strb=%b aluop=%b want 0010000/10", strb, alu_op); end
    tick(); tick();
    // CMP: 101/01 -> GETA, GETB, CMP, IF1
    bus.mem_rdata = 16'hA800;
    tick(); tick(); tick(); tick();
    total++; if (strb !== 7'b0001000 || alu_op !== 2'b01) begin bad++; $display("FAIL cmp_state strb=%b aluop=%b want 0001000/01", strb, alu_op); end
    tick();
    total++; if (bus.mem_cmd !== 2'b01 || strb !== 7'b0 || bus.mem_addr !== 9'd4) begin bad++; $display("FAIL cmp_nowrite cmd=%b strb=%b addr=%h", bus.mem_cmd, strb, bus.mem_addr); end
    // MVN: 101/11 goes straight to GETB
    bus.mem_rdata = 16'hB800;
    tick(); tick();
    total++; if (strb !== 7'b0100000 || nsel !== 3'b100) begin bad++; $display("FAIL mvn_getb strb=%b nsel=%b want 0100000/100", strb, nsel); end
    tick();
    total++; if (strb !== 7'b0010100 || alu_op !== 2'b11) begin bad++; $display("FAIL mvn_calc strb=%b aluop=%b want 0010100/11", strb, alu_op); end
    tick(); tick();
    // MOVreg with shift field 11
    bus.mem_rdata = 16'hC018;
    tick(); tick();
    total++; if (strb !== 7'b0100000 || shift !== 2'b11 || alu_op !== 2'b00) begin bad++; $display("FAIL movreg_getb strb=%b shift=%b aluop=%b", strb, shift, alu_op); end
    tick();
    total++; if (strb !== 7'b0010100) begin bad++; $display("FAIL movreg_calc strb=%b want 0010100", strb); end
    tick();
    total++; if (write !== 1'b1 || vsel !== 4'b1000) begin bad++; $display("FAIL movreg_wrc write=%b vsel=%b", write, vsel); end
    tick();
    total++; if (pc !== 9'd6 || bus.mem_addr !== 9'd6) begin bad++; $display("FAIL movreg_pc pc=%h addr=%h want 6", pc, bus.mem_addr); end
  endtask

  task automatic test_ldr();
    bus.mem_rdata = 16'h6000; dp_out = 16'hF123;
    tick(); tick();
    total++; if (strb !== 7'b1000000 || nsel !== 3'b001) begin bad++; $display("FAIL ldr_geta strb=%b nsel=%b", strb, nsel); end
    tick();
    total++; if (strb !== 7'b0010010 || alu_op !== 2'b00) begin bad++; $display("FAIL ldr_acalc strb=%b aluop=%b want 0010010/00", strb, alu_op); end
    tick();
    total++; if (strb !== 7'b0 || bus.mem_cmd !== 2'b00) begin bad++; $display("FAIL ldr_ldaddr strb=%b cmd=%b", strb, bus.mem_cmd); end
    bus.mem_ack = 1'b0;
    tick();
    dp_out = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'h123 || strb !== 7'b0) begin bad++; $display("FAIL ldr_wait%0d cmd=%b addr=%h strb=%b", i, bus.mem_cmd, bus.mem_addr, strb); end
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'h123 || strb !== 7'b0000001 || nsel !== 3'b010 || vsel !== 4'b0001) begin bad++; $display("FAIL ldr_ack cmd=%b addr=%h strb=%b nsel=%b vsel=%b", bus.mem_cmd, bus.mem_addr, strb, nsel, vsel); end
    tick();
    total++; if (strb !== 7'b0 || bus.mem_addr !== 9'd7) begin bad++; $display("FAIL ldr_done strb=%b addr=%h want 0/7", strb, bus.mem_addr); end
  endtask

  task automatic test_str_reset();
    bus.mem_rdata = 16'h8000; dp_out = 16'h0045;
    tick(); tick(); tick(); tick();
    bus.mem_ack = 1'b0;
    tick();
    total++; if (strb !== 7'b0100000 || nsel !== 3'b010) begin bad++; $display("FAIL str_getd strb=%b nsel=%b", strb, nsel); end
    tick();
    total++; if (strb !== 7'b0010100 || alu_op !== 2'b00) begin bad++; $display("FAIL str_pass strb=%b aluop=%b", strb, alu_op); end
    tick();
    total++; if (bus.mem_cmd !== 2'b10 || bus.mem_addr !== 9'h045) begin bad++; $display("FAIL str_memwr cmd=%b addr=%h want 10/045", bus.mem_cmd, bus.mem_addr); end
    tick();
    total++; if (bus.mem_cmd !== 2'b10) begin bad++; $display("FAIL str_hold cmd=%b want 10", bus.mem_cmd); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.mem_cmd !== 2'b00 || strb !== 7'b0 || pc !== 9'd0) begin bad++; $display("FAIL str_async cmd=%b strb=%b pc=%h", bus.mem_cmd, strb, pc); end
    @(negedge clk);
    reset = 1'b1; bus.mem_ack = 1'b1;
    tick();
    total++; if (bus.mem_cmd !== 2'b01 || bus.mem_addr !== 9'd0) begin bad++; $display("FAIL str_refetch cmd=%b addr=%h want 01/0", bus.mem_cmd, bus.mem_addr); end
  endtask

  task automatic test_wrap_halt();
    bus.mem_rdata = 16'hD007;
    for (int n = 0; n < 600 && pc !== 9'd511; n++) begin
      tick(); tick(); tick();
    end
    total++; if (pc !== 9'd511 || bus.mem_addr !== 9'd511) begin bad++; $display("FAIL wrap_reach pc=%h addr=%h want 1ff", pc, bus.mem_addr); end
    tick();
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL wrap_pc got=%h want=0", pc); end
    tick(); tick();
    bus.mem_rdata = 16'hE000;
    tick(); tick();
    total++; if (halted !== 1'b1 || illegal !== 1'b0 || bus.mem_cmd !== 2'b00) begin bad++; $display("FAIL halt_enter h=%b i=%b cmd=%b", halted, illegal, bus.mem_cmd); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (halted !== 1'b1 || bus.mem_cmd !== 2'b00 || pc !== 9'd1) begin bad++; $display("FAIL halt_hold%0d h=%b cmd=%b pc=%h", i, halted, bus.mem_cmd, pc); end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] vec [4];
    vec[0] = 16'h0000; vec[1] = 16'h6800; vec[2] = 16'hD800; vec[3] = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = 1'b1;
      do_reset();
      total++; if (illegal !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL ill_clear%0d i=%b h=%b", i, illegal, halted); end
      bus.mem_rdata = vec[i];
      tick(); tick();
      total++; if (halted !== 1'b1 || illegal !== 1'b1) begin bad++; $display("FAIL ill_trap%0d ir=%h h=%b i=%b want 1/1", i, ir, halted, illegal); end
    end
  endtask

  task automatic test_mem_wait();
    bus.mem_ack = 1'b0;
    do_reset();
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    total++; if (halted !== 1'b0 || bus_err !== 1'b0 || bus.mem_cmd !== 2'b01) begin bad++; $display("FAIL to_early h=%b e=%b cmd=%b", halted, bus_err, bus.mem_cmd); end
    tick();
    total++; if (halted !== 1'b1 || bus_err !== 1'b1) begin bad++; $display("FAIL to_fire h=%b e=%b want 1/1", halted, bus_err); end
    bus.mem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hD007;
    tick();
    total++; if (halted !== 1'b0 || bus_err !== 1'b0 || ir !== 16'hD007) begin bad++; $display("FAIL to_ackwins h=%b e=%b ir=%h", halted, bus_err, ir); end
`else
    for (int i = 0; i < 25; i++) tick();
    total++; if (halted !== 1'b0 || bus_err !== 1'b0 || bus.mem_cmd !== 2'b01 || pc !== 9'd0) begin bad++; $display("FAIL wait_unbounded h=%b e=%b cmd=%b pc=%h", halted, bus_err, bus.mem_cmd, pc); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hD007;
    tick();
    total++; if (ir !== 16'hD007 || pc !== 9'd1) begin bad++; $display("FAIL wait_late_ack ir=%h pc=%h", ir, pc); end
`endif
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    test_reset();
    test_movimm();
    test_add();
    test_alu_variants();
    test_ldr();
    test_str_reset();
    test_wrap_halt();
    test_illegal();
    test_mem_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
